// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch time-keeping datapath.
package stopwatch_pkg;
    localparam int unsigned DIGIT_W          = 4;
    localparam int unsigned SEC_TENS_MAX     = 5;
    localparam int unsigned DIGIT_MAX        = 9;
    localparam int unsigned TICK_DIV_DEFAULT = 100000000;
endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit counting 0..MAX; carry flags the MAX->0 rollover so digits can be chained.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = DIGIT_MAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] value,
    output logic               carry
);
    localparam logic [DIGIT_W-1:0] LIMIT = DIGIT_W'(MAX);

    always_comb begin
        carry = inc && (value == LIMIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clr || carry) begin
            value <= '0;
        end else if (inc) begin
            value <= value + 1'b1;
        end
    end
endmodule

// File: rtl/stopwatch_counter.sv
// Prescaled BCD MM:SS counter (00:00..99:59) driven by the run/pause enable cnt.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
    parameter int unsigned PRESC_W  = 27
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cnt,
    input  logic               clr,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] min_tens,
    output logic               tick,
    output logic               wrap
);
    localparam logic [PRESC_W-1:0] TERM = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc;
    logic               strobe;
    logic               c_so, c_st, c_mo, c_mt;

    always_comb begin
        strobe = cnt && (presc == TERM);
    end

    // Paused cycles leave presc untouched so resume picks up the partial second.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (clr) begin
            presc <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            if (strobe) begin
                presc <= '0;
            end else if (cnt) begin
                presc <= presc + 1'b1;
            end
            tick <= strobe;
            wrap <= c_mt;
        end
    end

    bcd_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk(clk), .rst(rst), .clr(clr), .inc(strobe), .value(sec_ones), .carry(c_so)
    );
    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .clr(clr), .inc(c_so), .value(sec_tens), .carry(c_st)
    );
    bcd_digit #(.MAX(DIGIT_MAX)) u_min_ones (
        .clk(clk), .rst(rst), .clr(clr), .inc(c_st), .value(min_ones), .carry(c_mo)
    );
    bcd_digit #(.MAX(DIGIT_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .clr(clr), .inc(c_mo), .value(min_tens), .carry(c_mt)
    );
endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Time-keeping datapath that consumes the `cnt` run/pause enable produced by the stopwatch control FSM.
- While `cnt` is high, a prescaler divides the system clock down to a 1 Hz-equivalent tick.
- Each tick advances a BCD minutes:seconds count, MM:SS from 00:00 to 99:59.
- Digit outputs feed the display driver; `tick` and `wrap` pulses are available to other logic.

Parameters:
- TICK_DIV, 100000000: system-clock cycles per count increment. Legal range is 2 or more. The bench overrides it to 4.
- PRESC_W, 27: prescaler width. It must satisfy 2^PRESC_W >= TICK_DIV.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cnt  in  1  run enable from the control FSM: 1 = run, 0 = pause.
- clr  in  1  synchronous clear, active-high; returns the count to 00:00.
- sec_ones  out  4  BCD seconds units, 0-9.
- sec_tens  out  4  BCD seconds tens, 0-5.
- min_ones  out  4  BCD minutes units, 0-9.
- min_tens  out  4  BCD minutes tens, 0-9.
- tick  out  1  one-cycle pulse, high in the cycle the new digit value is first visible.
- wrap  out  1  one-cycle pulse, high in the cycle 99:59 -> 00:00 becomes visible.

Behaviour:
- Reset:
  - rst low clears the prescaler, all four digits, `tick` and `wrap` to 0 immediately, independent of clk.
  - Release is synchronous to the next clk edge. No count occurs on the release edge unless the prescaler condition is met.
- Priority, evaluated per rising edge: rst (async) > clr > cnt.
- clr = 1:
  - Prescaler = 0, digits = 00:00, tick = 0, wrap = 0, regardless of cnt.
  - The counter holds while clr stays high.
- cnt = 0 (pause):
  - Prescaler and digits hold their value; the partial prescaler count is retained.
  - tick = 0, wrap = 0.
  - Resuming continues from the held prescaler value, so pause/resume loses no time.
- cnt = 1, prescaler < TICK_DIV-1:
  - Prescaler increments; digits hold; tick = 0.
- cnt = 1, prescaler == TICK_DIV-1:
  - Prescaler = 0, and the digits advance by one second on the same edge.
  - tick = 1 for exactly the following cycle.
  - One increment occurs every TICK_DIV enabled cycles. The first tick after clear/reset comes TICK_DIV enabled cycles after cnt first rises.
- BCD carry chain, all on the same edge:
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0 carries into min_ones.
  - min_ones 9 -> 0 carries into min_tens.
  - min_tens 9 -> 0 at 99:59 rolls the whole count to 00:00 and sets wrap = 1 for one cycle, coincident with tick.
  - Counting continues after the wrap; it does not saturate.
- Digits never take non-BCD values. sec_tens never exceeds 5. No intermediate values such as 00:60 are ever visible.
- Simultaneous events:
  - clr and a terminal prescaler count on the same edge: clr wins, so tick = 0 and wrap = 0.
  - cnt falling in the same cycle the prescaler would reach its terminal value: no increment.
- Internal FSM: none beyond the prescaler and the digit counters. Run/pause state is owned entirely by the upstream FSM via cnt.
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Shared package `stopwatch_pkg` holds:
  - BCD digit width (4);
  - digit limits: SEC_TENS_MAX = 5, DIGIT_MAX = 9;
  - the default TICK_DIV.
- One natural sub-module, `bcd_digit`:
  - Parameterised by MAX.
  - Inputs: clk, rst, clr, inc.
  - Outputs: a 4-bit value and carry, where carry = inc && value == MAX.
  - Instantiated four times: MAX = 9, 5, 9, 9. Each inc is chained from the previous carry.
  - The first inc is the prescaler terminal strobe.

Test Plan:
- Reset: assert rst low mid-count at digits 00:07 with prescaler 2 -> all outputs read 0 within the same cycle, no clk edge needed. After release with cnt = 1, the first tick arrives exactly 4 cycles later and shows 00:01.
- Basic rate, TICK_DIV = 4: cnt held high for 40 cycles from 00:00 -> exactly 10 tick pulses, each one cycle wide. Digits read 00:10 and increment only on tick cycles.
- Pause/resume: run 6 cycles (00:01, prescaler 2), drop cnt for 20 cycles, raise cnt again.
  - Digits hold at 00:01 and tick stays 0 while paused.
  - The next tick comes 2 enabled cycles after resume.
- Carry chain:
  - Preload by running to 00:59 -> the next tick shows 01:00.
  - Run to 09:59 -> the next tick shows 10:00.
  - At no point is a digit above its limit.
- Wrap: run to 99:59 -> the next tick shows 00:00 with wrap = 1 and tick = 1 in the same single cycle. The following tick shows 00:01 with wrap = 0.
- Clear priority: assert clr on the cycle the prescaler equals 3 at 00:05 -> digits 00:00, tick = 0, wrap = 0. With clr low and cnt high, the first tick comes 4 cycles later.
